// File: rtl/count_wrap_monitor.sv
// Property monitor for a selector-gated modulo counter (wraps LIMIT -> 1).
// Tracks a shadow of the expected count, flags range/sequence violations, counts wraps.
module count_wrap_monitor #(
  parameter int WIDTH  = 11,
  parameter int LIMIT  = 500,
  parameter int WCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              selector,
  input  logic [WIDTH-1:0]  c,
  input  logic              clr,
  output logic              mismatch,
  output logic              err_sticky,
  output logic [1:0]        err_code,
  output logic              wrap,
  output logic [WCNT_W-1:0] wrap_count,
  output logic [WCNT_W-1:0] err_count,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {S_INIT = 2'd0, S_RUN = 2'd1, S_FAIL = 2'd2} state_t;

  localparam logic [WIDTH-1:0] LIM = LIMIT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    exp_q, exp_d;
  logic                mismatch_q, mismatch_d;
  logic                err_sticky_q, err_sticky_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                wrap_q, wrap_d;
  logic [WCNT_W-1:0]   wrap_count_q, wrap_count_d;
  logic [WCNT_W-1:0]   err_count_q, err_count_d;

  logic                range_err, seq_err, viol, wrap_ev;
  logic [WIDTH-1:0]    base;

  always_comb begin
    range_err = (c > LIM);
    seq_err   = (c != exp_q);
    viol      = range_err | seq_err;
    wrap_ev   = selector && (c == LIM) && !range_err;

    // Resync to the observed value on a violation so one glitch reports once
    base  = viol ? c : exp_q;
    exp_d = base;
    if (selector) exp_d = (base == LIM) ? ONE : base + ONE;

    mismatch_d = viol;
    wrap_d     = wrap_ev;

    // clr clears first, then this cycle's events are applied on top
    wrap_count_d = clr ? '0 : wrap_count_q;
    if (wrap_ev && !(&wrap_count_d)) wrap_count_d = wrap_count_d + 1'b1;
    err_count_d = clr ? '0 : err_count_q;
    if (viol && !(&err_count_d)) err_count_d = err_count_d + 1'b1;

    err_code_d   = (clr ? 2'b00 : err_code_q) | {seq_err, range_err};
    err_sticky_d = (clr ? 1'b0 : err_sticky_q) | viol;

    state_d = state_q;
    if (viol)                          state_d = S_FAIL;
    else if (state_q == S_FAIL && clr) state_d = (wrap_count_q != '0) ? S_RUN : S_INIT;
    else if (state_q == S_INIT && wrap_ev) state_d = S_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      exp_q        <= '0;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      err_code_q   <= 2'b00;
      wrap_q       <= 1'b0;
      wrap_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      mismatch_q   <= mismatch_d;
      err_sticky_q <= err_sticky_d;
      err_code_q   <= err_code_d;
      wrap_q       <= wrap_d;
      wrap_count_q <= wrap_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign mismatch   = mismatch_q;
  assign err_sticky = err_sticky_q;
  assign err_code   = err_code_q;
  assign wrap       = wrap_q;
  assign wrap_count = wrap_count_q;
  assign err_count  = err_count_q;
  assign state      = state_q;

endmodule
